// File: rtl/process2_monitor_pkg.sv
// Shared types and constants for the process2_monitor sequencer.
// The count slice helper keeps flattened-bus indexing in one place.
package process2_monitor_pkg;

    localparam int PR2_NB_MONITOR     = 43;
    localparam int PR2_COUNT_W        = 16;
    localparam int PR2_TARGET_W       = 4;
    localparam int PR2_SETUP_CYCLES   = 4;
    localparam int PR2_DISABLE_CYCLES = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_RUN,
        ST_CAPTURE,
        ST_DISABLE,
        ST_WAIT
    } pm_state_e;

    function automatic logic [PR2_COUNT_W-1:0] count_slice(
        input logic [PR2_NB_MONITOR*PR2_COUNT_W-1:0] flat,
        input int                                    idx
    );
        return flat[idx*PR2_COUNT_W +: PR2_COUNT_W];
    endfunction

endpackage

// File: rtl/process2_monitor_result_bank.sv
// Result bank for the 43 ring-oscillator counts: masked capture,
// low-threshold compare on the live counts and a combinational read port.
module process2_monitor_result_bank
    import process2_monitor_pkg::*;
(
    input  logic                                   clock,
    input  logic                                   rst,
    input  logic                                   cap_en,
    input  logic [PR2_NB_MONITOR-1:0]              mask,
    input  logic [PR2_COUNT_W-1:0]                 thr_low,
    input  logic [PR2_NB_MONITOR*PR2_COUNT_W-1:0]  pm_count,
    input  logic [5:0]                             rd_idx,
    output logic [PR2_COUNT_W-1:0]                 rd_data,
    output logic                                   any_low
);

    logic [PR2_COUNT_W-1:0] result [PR2_NB_MONITOR];

    // NOTE: this bank is a reset register array, not a RAM: software relies on
    // reading zeros after reset, so every entry is cleared by rst.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PR2_NB_MONITOR; i++) begin
                result[i] <= '0;
            end
        end else if (cap_en) begin
            for (int i = 0; i < PR2_NB_MONITOR; i++) begin
                result[i] <= mask[i] ? count_slice(pm_count, i) : '0;
            end
        end
    end

    // NOTE: defaults first in every always_comb so no path leaves a latch behind.
    always_comb begin
        any_low = 1'b0;
        for (int i = 0; i < PR2_NB_MONITOR; i++) begin
            if (mask[i] && (count_slice(pm_count, i) < thr_low)) begin
                any_low = 1'b1;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (int'(rd_idx) < PR2_NB_MONITOR) begin
            rd_data = result[rd_idx];
        end
    end

endmodule

// File: rtl/process2_monitor_ctrl.sv
// Sequencer for one process2_monitor macro: setup, run, capture, disable,
// optional periodic wait, with run timeout and low-count alarm.
module process2_monitor_ctrl
    import process2_monitor_pkg::*;
#(
    parameter int SETUP_CYCLES = PR2_SETUP_CYCLES,
    parameter int TIMEOUT_W    = 24,
    parameter int INTERVAL_W   = 32,
    parameter int NB_MON       = PR2_NB_MONITOR,
    parameter int COUNT_W      = PR2_COUNT_W
) (
    input  logic                      clock,
    input  logic                      rst,
    input  logic                      cfg_start,
    input  logic                      cfg_stop,
    input  logic                      cfg_periodic,
    input  logic [INTERVAL_W-1:0]     cfg_interval,
    input  logic [TIMEOUT_W-1:0]      cfg_timeout,
    input  logic [PR2_TARGET_W-1:0]   cfg_target,
    input  logic [NB_MON-1:0]         cfg_use_ro,
    input  logic [COUNT_W-1:0]        cfg_thr_low,
    output logic                      busy,
    output logic                      done,
    output logic                      timeout_err,
    output logic                      alarm,
    output logic [15:0]               run_cnt,
    input  logic [5:0]                rd_idx,
    output logic [COUNT_W-1:0]        rd_data,
    output logic                      pm_enable,
    output logic [PR2_TARGET_W-1:0]   pm_target,
    output logic [NB_MON-1:0]         pm_use_ro,
    input  logic                      pm_valid,
    input  logic [NB_MON*COUNT_W-1:0] pm_count
);

    localparam int PHASE_W = 8;

    pm_state_e               state;
    logic [PHASE_W-1:0]      phase_cnt;
    logic [TIMEOUT_W-1:0]    run_tmr;
    logic [INTERVAL_W-1:0]   wait_cnt;
    logic                    stop_pend;
    logic                    periodic_sh;
    logic [INTERVAL_W-1:0]   interval_sh;
    logic [TIMEOUT_W-1:0]    timeout_sh;
    logic [COUNT_W-1:0]      thr_sh;
    logic                    cap_en;
    logic                    any_low;

    assign cap_en = (state == ST_CAPTURE);

    // pm_target/pm_use_ro are the shadow registers themselves, so they can only
    // move on the IDLE->SETUP edge while pm_enable is low.
    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            phase_cnt   <= '0;
            run_tmr     <= '0;
            wait_cnt    <= '0;
            stop_pend   <= 1'b0;
            periodic_sh <= 1'b0;
            interval_sh <= '0;
            timeout_sh  <= '0;
            thr_sh      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            alarm       <= 1'b0;
            run_cnt     <= '0;
            pm_enable   <= 1'b0;
            pm_target   <= '0;
            pm_use_ro   <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (cfg_start && !cfg_stop) begin
                        pm_target   <= cfg_target;
                        pm_use_ro   <= cfg_use_ro;
                        thr_sh      <= cfg_thr_low;
                        periodic_sh <= cfg_periodic;
                        interval_sh <= cfg_interval;
                        timeout_sh  <= cfg_timeout;
                        timeout_err <= 1'b0;
                        alarm       <= 1'b0;
                        run_cnt     <= '0;
                        stop_pend   <= 1'b0;
                        phase_cnt   <= '0;
                        busy        <= 1'b1;
                        state       <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    if (cfg_stop) begin
                        stop_pend <= 1'b1;
                        phase_cnt <= '0;
                        state     <= ST_DISABLE;
                    end else if (phase_cnt == PHASE_W'(SETUP_CYCLES - 1)) begin
                        run_tmr   <= '0;
                        pm_enable <= 1'b1;
                        state     <= ST_RUN;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end

                ST_RUN: begin
                    if (cfg_stop) begin
                        stop_pend <= 1'b1;
                        phase_cnt <= '0;
                        pm_enable <= 1'b0;
                        state     <= ST_DISABLE;
                    end else if (pm_valid) begin
                        state <= ST_CAPTURE;
                    end else if ((timeout_sh != '0) &&
                                 (run_tmr + TIMEOUT_W'(1) == timeout_sh)) begin
                        timeout_err <= 1'b1;
                        phase_cnt   <= '0;
                        pm_enable   <= 1'b0;
                        state       <= ST_DISABLE;
                    end else begin
                        run_tmr <= run_tmr + TIMEOUT_W'(1);
                    end
                end

                // The bank captures on this same edge; done lines up with fresh results.
                ST_CAPTURE: begin
                    done      <= 1'b1;
                    alarm     <= alarm | any_low;
                    if (run_cnt != 16'hFFFF) begin
                        run_cnt <= run_cnt + 16'd1;
                    end
                    if (cfg_stop) begin
                        stop_pend <= 1'b1;
                    end
                    phase_cnt <= '0;
                    pm_enable <= 1'b0;
                    state     <= ST_DISABLE;
                end

                ST_DISABLE: begin
                    if (phase_cnt == PHASE_W'(PR2_DISABLE_CYCLES - 1)) begin
                        if (periodic_sh && !stop_pend && !cfg_stop) begin
                            if (interval_sh == '0) begin
                                phase_cnt <= '0;
                                state     <= ST_SETUP;
                            end else begin
                                wait_cnt <= interval_sh;
                                state    <= ST_WAIT;
                            end
                        end else begin
                            stop_pend <= 1'b0;
                            busy      <= 1'b0;
                            state     <= ST_IDLE;
                        end
                    end else begin
                        if (cfg_stop) begin
                            stop_pend <= 1'b1;
                        end
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end

                ST_WAIT: begin
                    if (cfg_stop) begin
                        stop_pend <= 1'b1;
                        phase_cnt <= '0;
                        state     <= ST_DISABLE;
                    end else if (wait_cnt == INTERVAL_W'(1)) begin
                        phase_cnt <= '0;
                        state     <= ST_SETUP;
                    end else begin
                        wait_cnt <= wait_cnt - INTERVAL_W'(1);
                    end
                end

                default: begin
                    busy      <= 1'b0;
                    pm_enable <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

    process2_monitor_result_bank u_bank (
        .clock    (clock),
        .rst      (rst),
        .cap_en   (cap_en),
        .mask     (pm_use_ro),
        .thr_low  (thr_sh),
        .pm_count (pm_count),
        .rd_idx   (rd_idx),
        .rd_data  (rd_data),
        .any_low  (any_low)
    );

endmodule
